// File: rtl/spike_isi_monitor.sv
// spike_isi_monitor: measures inter-spike intervals into a FWFT FIFO and reports windowed spike rate
module spike_isi_monitor #(
   parameter int CNT_W = 16,
   parameter int DEPTH = 8,
   parameter int WIN_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       spike_in,
   input  logic                       clear,
   input  logic [WIN_W-1:0]           win_len,
   output logic [CNT_W-1:0]           isi_data,
   output logic                       isi_valid,
   input  logic                       isi_ready,
   output logic                       isi_overflow,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic [7:0]                 rate_count,
   output logic                       rate_valid
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {IDLE, TIMING} state_t;

   state_t           state;
   logic             spike_prev;
   logic [CNT_W-1:0] isi_cnt;
   logic [CNT_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIN_W-1:0] win_lim;
   logic [WIN_W-1:0] win_cnt;
   logic [7:0]       rate_acc;
   logic [7:0]       acc_next;
   logic             ev;
   logic             push;
   logic             pop;
   logic             full;
   logic             do_push;

   assign ev        = spike_in & ~spike_prev;
   assign push      = ev & (state == TIMING);
   assign isi_valid = fifo_level != '0;
   assign pop       = isi_valid & isi_ready;
   assign full      = fifo_level == LW'(DEPTH);
   assign do_push   = push & (~full | pop);
   assign isi_data  = isi_valid ? mem[rd_ptr] : '0;
   assign acc_next  = (ev && rate_acc != 8'hFF) ? rate_acc + 8'd1 : rate_acc;

   // previous spike sample for rising-edge detection; kept running through clear so a held spike is not recounted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) spike_prev <= 1'b0;
      else spike_prev <= spike_in;
   end

   // interval FSM: first edge arms the timer, later edges restart it at 1 after the push
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         isi_cnt <= '0;
      end else if (clear) begin
         state   <= IDLE;
         isi_cnt <= '0;
      end else if (ev) begin
         state   <= TIMING;
         isi_cnt <= CNT_W'(1);
      end else if (state == TIMING && isi_cnt != CNT_MAX) begin
         isi_cnt <= isi_cnt + 1'b1;
      end
   end

   // FIFO storage; contents need no reset because pointers and level define validity
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= isi_cnt;
   end

   // FIFO pointers, occupancy and sticky overflow; a full FIFO still accepts when popped in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level   <= '0;
         isi_overflow <= 1'b0;
      end else if (clear) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level   <= '0;
         isi_overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !pop) fifo_level <= fifo_level + 1'b1;
         else if (pop && !do_push) fifo_level <= fifo_level - 1'b1;
         if (push && full && !pop) isi_overflow <= 1'b1;
      end
   end

   // rate window: a zero limit idles and re-samples win_len each cycle; otherwise count to the limit then report
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_lim    <= '0;
         win_cnt    <= '0;
         rate_acc   <= '0;
         rate_count <= '0;
         rate_valid <= 1'b0;
      end else if (clear) begin
         win_lim    <= '0;
         win_cnt    <= '0;
         rate_acc   <= '0;
         rate_count <= '0;
         rate_valid <= 1'b0;
      end else if (win_lim == '0) begin
         win_lim    <= win_len;
         rate_valid <= 1'b0;
      end else if (win_cnt == win_lim - 1'b1) begin
         rate_count <= acc_next;
         rate_valid <= 1'b1;
         rate_acc   <= '0;
         win_cnt    <= '0;
         win_lim    <= win_len;
      end else begin
         win_cnt    <= win_cnt + 1'b1;
         rate_acc   <= acc_next;
         rate_valid <= 1'b0;
      end
   end
endmodule

// File: doc/spike_isi_monitor.md
Name: spike_isi_monitor

Overview:
Downstream consumer of the Izhikevich neuron core's 1-bit spike output. It detects spike rising edges and measures the inter-spike interval (ISI) in clock cycles. Measured ISIs are buffered in a small first-word-fall-through FIFO with a valid/ready read port. It also reports the spike count per programmable time window, so firing patterns (RS, IB, CH, FS, ...) can be characterised on-chip.

Parameters:
CNT_W, 16, width of the ISI counter and of FIFO entries
DEPTH, 8, FIFO depth in entries (power of two, >= 2)
WIN_W, 16, width of the window-length input and window counter

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
spike_in  in  1  spike output of the neuron core, synchronous to clk
clear  in  1  synchronous soft clear; same effect as reset
win_len  in  WIN_W  rate-window length in cycles; 0 disables rate reporting
isi_data  out  CNT_W  head-of-FIFO ISI value
isi_valid  out  1  FIFO not empty
isi_ready  in  1  consumer accepts isi_data when isi_valid is high
isi_overflow  out  1  sticky flag: an ISI was dropped because the FIFO was full
fifo_level  out  $clog2(DEPTH)+1  number of stored entries
rate_count  out  8  spike count of the last completed window
rate_valid  out  1  one-cycle pulse when rate_count updates

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, FIFO empty, spike_prev=0, FSM in IDLE, window counter 0.
- Asynchronous reset may assert mid-operation; all state is lost with no partial pops.
- Edge detect: event = spike_in & ~spike_prev; spike_prev is registered each cycle.
- A multi-cycle high spike is one event.
- A spike_in already high at the first cycle after reset counts as an event.
- FSM IDLE: no reference spike yet. On event: isi_cnt <= 1, go to TIMING, push nothing.
- FSM TIMING: isi_cnt increments each cycle and saturates at 2^CNT_W-1. On event: push the current isi_cnt value, then isi_cnt <= 1.
- Pushed ISI = exact cycle distance between the two event cycles. Events at cycles t0 and t1 push t1-t0.
- A saturated count is pushed as all-ones.
- FIFO write occurs at the event edge; isi_valid/isi_data reflect the new entry on the next cycle (latency 1).
- Pop occurs when isi_valid & isi_ready. isi_data is combinational from the head entry (FWFT).
- Full with push and no pop: the entry is dropped, isi_overflow <= 1, contents unchanged.
- Full with push and pop in the same cycle: both take effect; level stays DEPTH; no overflow.
- Empty with push and isi_ready high in the same cycle: push only, since isi_valid was 0.
- Pointers wrap modulo DEPTH; fifo_level is exact from 0 to DEPTH.
- Rate window: win_len is latched at window start into win_lim.
- Window counter runs 0..win_lim-1. rate_acc counts events and saturates at 255.
- On the last window cycle: rate_count <= rate_acc plus any event in that cycle (saturating), rate_valid pulses 1, rate_acc <= 0, counter <= 0, win_len is re-latched.
- If the latched win_len is 0, the window logic is idle and rate_valid stays 0. A nonzero win_len is picked up on the next cycle.
- clear=1: FIFO emptied, isi_overflow <= 0, FSM -> IDLE, isi_cnt/rate_acc/window counter <= 0, rate_count <= 0, rate_valid <= 0.
- clear overrides any event, push or pop in the same cycle; an event in the clear cycle is ignored.
- Outputs isi_overflow, rate_count, rate_valid and fifo_level are registered.

Test Plan:
- Reset release, spike pulses at cycles 10, 35, 95, isi_ready=1 -> first event pushes nothing; entries 25 then 60 appear on isi_valid one cycle after cycles 35 and 95.
- spike_in high for 4 cycles from cycle 10, then high again at cycle 20 -> single entry of 10 pushed; no extra events.
- isi_ready=0 with 10 spikes every 5 cycles (DEPTH=8) -> first spike pushes nothing; 8 entries of value 5 stored; the 9th push is dropped, isi_overflow=1, fifo_level=8. Then isi_ready=1 drains 8 values of 5 in order.
- Full FIFO, event coincides with isi_ready=1 pop -> fifo_level stays 8, isi_overflow stays 0, the new value sits at the tail.
- win_len=100, spikes every 20 cycles starting at cycle 5 of the window -> rate_valid pulses every 100 cycles with rate_count=5. Then win_len=0 -> no further rate_valid pulses.
- No spikes for 70000 cycles after a first event (CNT_W=16), then a spike -> pushed value 0xFFFF. Then assert clear with a coincident spike -> FIFO empty, overflow 0, FSM in IDLE, and the next spike pushes nothing.
